golden_nonce_fifo: RTL and testbench
====================================

Name: golden_nonce_fifo

Overview:
- Buffers golden nonces reported by the hashing core (got_ticket / golden_nonce) in the hash_clk domain and presents them one at a time to the JTAG communication layer through a valid/ready handshake.
- Replaces the lossy fixed-depth shift register, so back-to-back tickets are not dropped.
- Applies a fixed pipeline nonce correction and discards stale results when new work arrives.

Parameters:
- DEPTH, 8, number of nonce entries; power of two, 2..64.
- NONCE_ADJUST, 32'd0, value subtracted modulo 2^32 from every incoming nonce to cancel core pipeline offset.
- DROP_CNT_W, 16, width of the saturating dropped-nonce counter.

Ports:
- clk  in  1  hash clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- in_got_ticket  in  1  single-cycle strobe from core: golden_nonce valid this cycle.
- in_golden_nonce  in  32  raw nonce from core.
- flush  in  1  new-work strobe; discards all buffered nonces.
- out_valid  out  1  out_nonce holds a valid entry.
- out_nonce  out  32  adjusted nonce at FIFO head.
- out_ready  in  1  consumer accepts head when out_valid && out_ready.
- level  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one nonce dropped since reset or last flush.
- drop_count  out  DROP_CNT_W  saturating count of dropped nonces; cleared by flush.

Behaviour:
- Reset (async, rst_n low): out_valid=0, out_nonce=0, level=0, overflow=0, drop_count=0, read/write pointers=0. Memory contents are don't-care.
- Push: on a cycle with in_got_ticket=1, store (in_golden_nonce - NONCE_ADJUST) mod 2^32.
- Pop: occurs when out_valid && out_ready at the clock edge; head advances.
- Latency: a push into an empty FIFO gives out_valid=1 and out_nonce = the adjusted value on the next edge, i.e. 1 cycle.
- out_nonce is registered and stable while out_valid=1 && out_ready=0. The consumer may hold out_ready high permanently.
- Ordering: strict FIFO.
- Full (level==DEPTH):
  - Push without pop: the incoming nonce is dropped, overflow<=1, drop_count increments and saturates at all-ones.
  - Push with pop in the same cycle: both succeed and level is unchanged.
- Empty: a pop is impossible because out_valid=0, and out_ready is ignored.
- Pointers wrap modulo DEPTH. level is computed from pointer difference including the wrap bit.
- Simultaneous push and pop on a non-full FIFO: level unchanged, no loss.
- flush:
  - On the next edge, level=0, out_valid=0, overflow=0, drop_count=0, pointers=0.
  - flush has priority over a same-cycle push and pop. The incoming nonce belongs to old work and is discarded without counting as a drop.
- De-asserting rst_n mid-operation: the FIFO is empty on the first edge after release. In-flight handshakes are abandoned.
- in_got_ticket held high for several cycles is treated as one push per cycle.

Optional Feature:
- Macro: GOLDEN_NONCE_DEDUP_EN.
- Defined:
  - A 32-bit last_pushed register plus a valid bit, both cleared by reset and flush.
  - A push whose adjusted nonce equals last_pushed while the valid bit is set is silently discarded. It does not count as a drop and does not set overflow.
  - This guards against the core re-reporting the same ticket across duplicated pipeline stages.
- Undefined: no compare logic is present and every push is stored.

Test Plan:
- Reset, then a single push: NONCE_ADJUST=5, in_golden_nonce=32'h00000105 for 1 cycle -> next cycle out_valid=1, out_nonce=32'h00000100, level=1. Hold out_ready=1 for 1 cycle -> out_valid=0, level=0.
- Wrap arithmetic: NONCE_ADJUST=5, nonce 32'h00000002 -> out_nonce=32'hFFFFFFFD.
- Burst with consumer stalled: DEPTH=8, 10 consecutive tickets 1..10, out_ready=0 -> level=8, overflow=1, drop_count=2. Drain -> nonces emerge in order 1..8 and level returns to 0.
- Full with same-cycle push and pop: fill to 8, then push 99 with out_ready=1 -> level stays 8, no overflow, and 99 emerges last.
- Flush priority: 3 entries buffered, then assert flush together with a ticket of 7 -> next cycle level=0, out_valid=0, and 7 is never output. A ticket of 8 one cycle later is output normally.
- Dedup (GOLDEN_NONCE_DEDUP_EN defined): push 42, 42, 43 -> outputs 42, 43, drop_count=0. Flush, then push 42 -> 42 is output again.

Source files
------------

// File: rtl/golden_nonce_fifo.sv
// ============================================================================
// Module  : golden_nonce_fifo
// Purpose : Buffers golden nonces from the hashing core (adjusted by
//           NONCE_ADJUST) and hands them one at a time to the JTAG layer
//           through a valid/ready handshake.
//           Optional duplicate-ticket filter: GOLDEN_NONCE_DEDUP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module golden_nonce_fifo #(
  parameter int          DEPTH        = 8,
  parameter logic [31:0] NONCE_ADJUST = 32'd0,
  parameter int          DROP_CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_got_ticket,
  input  logic [31:0]             in_golden_nonce,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [31:0]             out_nonce,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  output logic [DROP_CNT_W-1:0]   drop_count
);

  localparam int               c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [c_AW:0] r_wr_ptr;
  logic [c_AW:0] r_rd_ptr;
  logic          r_out_valid;
  logic [31:0]   r_out_nonce;
  logic          r_overflow;
  logic [DROP_CNT_W-1:0] r_drop_count;

  logic [31:0]   w_adj;
  logic          w_full;
  logic          w_pop;
  logic          w_dup;
  logic          w_push_ok;
  logic          w_drop;
  logic [c_AW:0] w_rd_next;
  logic [c_AW:0] w_wr_next;
  logic [c_AW:0] w_lvl_next;
  logic [31:0]   w_head_next;

  assign w_adj      = in_golden_nonce - NONCE_ADJUST;
  assign level      = r_wr_ptr - r_rd_ptr;
  assign w_full     = (level == c_FULL);
  assign w_pop      = r_out_valid && out_ready;
  assign w_push_ok  = in_got_ticket && !flush && !w_dup && (!w_full || w_pop);
  assign w_drop     = in_got_ticket && !flush && !w_dup && w_full && !w_pop;
  assign w_rd_next  = r_rd_ptr + {{c_AW{1'b0}}, w_pop};
  assign w_wr_next  = r_wr_ptr + {{c_AW{1'b0}}, w_push_ok};
  assign w_lvl_next = w_wr_next - w_rd_next;

`ifdef GOLDEN_NONCE_DEDUP_EN
  logic [31:0] r_last_pushed;
  logic        r_last_valid;

  assign w_dup = r_last_valid && (r_last_pushed == w_adj);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_pushed <= 32'd0;
      r_last_valid  <= 1'b0;
    end else if (flush) begin
      r_last_pushed <= 32'd0;
      r_last_valid  <= 1'b0;
    end else if (in_got_ticket) begin
      r_last_pushed <= w_adj;
      r_last_valid  <= 1'b1;
    end
  end
`else
  assign w_dup = 1'b0;
`endif

  // The head register is loaded one edge ahead; when the entry being written
  // becomes the new head, bypass the memory so empty-FIFO latency is 1 cycle.
  always_comb begin
    w_head_next = r_out_nonce;
    if (w_push_ok && (w_rd_next == r_wr_ptr))
      w_head_next = w_adj;
    else if (w_lvl_next != '0)
      w_head_next = r_mem[w_rd_next[c_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[c_AW-1:0]] <= w_adj;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_out_valid  <= 1'b0;
      r_out_nonce  <= 32'd0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_out_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_wr_ptr    <= w_wr_next;
      r_rd_ptr    <= w_rd_next;
      r_out_valid <= (w_lvl_next != '0);
      r_out_nonce <= w_head_next;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_count != {DROP_CNT_W{1'b1}})
          r_drop_count <= r_drop_count + 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_nonce  = r_out_nonce;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

`default_nettype wire

// File: tb/tb_golden_nonce_fifo.sv
// ============================================================================
// Module  : tb_golden_nonce_fifo
// Purpose : Directed vector bench for golden_nonce_fifo (DEPTH=8, adjust=5).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_golden_nonce_fifo;

  localparam logic [31:0] c_ADJ = 32'd5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_got_ticket = 1'b0;
  logic [31:0] in_golden_nonce = 32'd0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [31:0] out_nonce;
  logic        out_ready = 1'b0;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  golden_nonce_fifo #(
    .DEPTH(8),
    .NONCE_ADJUST(c_ADJ),
    .DROP_CNT_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_got_ticket(in_got_ticket),
    .in_golden_nonce(in_golden_nonce),
    .flush(flush),
    .out_valid(out_valid),
    .out_nonce(out_nonce),
    .out_ready(out_ready),
    .level(level),
    .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        push;
    logic [31:0] raw;
    logic        fl;
    logic        rdy;
    logic        ev;
    logic [31:0] en;
    logic [3:0]  el;
    logic        eo;
    logic [15:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic push, input logic [31:0] raw,
                     input logic fl, input logic rdy, input logic ev,
                     input logic [31:0] en, input logic [3:0] el,
                     input logic eo, input logic [15:0] ed);
    vec_t v;
    v.name = name; v.push = push; v.raw = raw; v.fl = fl; v.rdy = rdy;
    v.ev = ev; v.en = en; v.el = el; v.eo = eo; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic ev, input logic [31:0] en,
                           input logic [3:0] el, input logic eo, input logic [15:0] ed);
    check({name, ".valid"}, {31'd0, out_valid}, {31'd0, ev});
    if (ev) check({name, ".nonce"}, out_nonce, en);
    check({name, ".level"}, {28'd0, level}, {28'd0, el});
    check({name, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
    check({name, ".drops"}, {16'd0, drop_count}, {16'd0, ed});
  endtask

  task automatic step(input logic push, input logic [31:0] raw, input logic fl, input logic rdy);
    in_got_ticket   = push;
    in_golden_nonce = raw;
    flush           = fl;
    out_ready       = rdy;
    @(posedge clk);
    #1;
    in_got_ticket = 1'b0;
    flush         = 1'b0;
    out_ready     = 1'b0;
  endtask

  initial begin
    // Single push / pop and modular adjust
    add("single_push", 1, 32'h105, 0, 0, 1, 32'h100, 1, 0, 0);
    add("single_pop",  0, 0,       0, 1, 0, 32'h0,   0, 0, 0);
    add("wrap_push",   1, 32'h2,   0, 0, 1, 32'hFFFFFFFD, 1, 0, 0);
    add("wrap_pop",    0, 0,       0, 1, 0, 32'h0,   0, 0, 0);
    // Stalled burst of 10 into depth 8: head stays 1, last two dropped
    for (int k = 1; k <= 10; k++)
      add($sformatf("burst%0d", k), 1, 32'(k) + c_ADJ, 0, 0, 1, 32'd1,
          (k > 8) ? 4'd8 : 4'(k), (k > 8), (k > 8) ? 16'(k - 8) : 16'd0);
    for (int j = 1; j <= 8; j++)
      add($sformatf("drain%0d", j), 0, 0, 0, 1, (j < 8), 32'(j + 1), 4'(8 - j), 1, 2);
    add("flush_clr", 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // Fill then push+pop while full
    for (int k = 1; k <= 8; k++)
      add($sformatf("fill%0d", k), 1, 32'(10 + k) + c_ADJ, 0, 0, 1, 32'd11, 4'(k), 0, 0);
    add("full_pushpop", 1, 32'd99 + c_ADJ, 0, 1, 1, 32'd12, 8, 0, 0);
    for (int j = 1; j <= 8; j++)
      add($sformatf("fdrain%0d", j), 0, 0, 0, 1, (j < 8),
          (j == 7) ? 32'd99 : 32'(12 + j), 4'(8 - j), 0, 0);
    // Flush beats a same-cycle push and pop
    add("fp_push1", 1, 32'd21 + c_ADJ, 0, 0, 1, 32'd21, 1, 0, 0);
    add("fp_push2", 1, 32'd22 + c_ADJ, 0, 0, 1, 32'd21, 2, 0, 0);
    add("fp_push3", 1, 32'd23 + c_ADJ, 0, 0, 1, 32'd21, 3, 0, 0);
    add("fp_flush", 1, 32'd7 + c_ADJ,  1, 1, 0, 32'd0,  0, 0, 0);
    add("fp_after", 1, 32'd8 + c_ADJ,  0, 0, 1, 32'd8,  1, 0, 0);
    add("fp_pop",   0, 0,              0, 1, 0, 32'd0,  0, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    check("reset.nonce", out_nonce, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      step(vecs[i].push, vecs[i].raw, vecs[i].fl, vecs[i].rdy);
      check_all(vecs[i].name, vecs[i].ev, vecs[i].en, vecs[i].el, vecs[i].eo, vecs[i].ed);
    end

    // Asynchronous reset mid-operation abandons buffered entries
    step(1, 32'd50 + c_ADJ, 0, 0);
    step(1, 32'd51 + c_ADJ, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    check("async_rst.nonce", out_nonce, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 1);
    check_all("post_rst", 0, 0, 0, 0, 0);

`ifdef GOLDEN_NONCE_DEDUP_EN
    step(1, 32'd42 + c_ADJ, 0, 0);
    check_all("dedup_a", 1, 32'd42, 1, 0, 0);
    step(1, 32'd42 + c_ADJ, 0, 0);
    check_all("dedup_dup", 1, 32'd42, 1, 0, 0);
    step(1, 32'd43 + c_ADJ, 0, 0);
    check_all("dedup_b", 1, 32'd42, 2, 0, 0);
    step(0, 0, 0, 1);
    check_all("dedup_pop1", 1, 32'd43, 1, 0, 0);
    step(0, 0, 0, 1);
    check_all("dedup_pop2", 0, 0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(1, 32'd42 + c_ADJ, 0, 0);
    check_all("dedup_reflush", 1, 32'd42, 1, 0, 0);
`else
    step(1, 32'd42 + c_ADJ, 0, 0);
    step(1, 32'd42 + c_ADJ, 0, 0);
    check_all("nodedup", 1, 32'd42, 2, 0, 0);
    step(0, 0, 0, 1);
    check_all("nodedup_pop", 1, 32'd42, 1, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
